// File: rtl/issue_ctrl_pkg.sv
// Shared Ch0re types: major opcodes, issue-stage states and a register one-hot helper.
package ch0re_types;

   typedef enum logic [4:0] {
      OPC_LOAD     = 5'b00000,
      OPC_MISC_MEM = 5'b00011,
      OPC_OP_IMM   = 5'b00100,
      OPC_AUIPC    = 5'b00101,
      OPC_OP_IMM32 = 5'b00110,
      OPC_STORE    = 5'b01000,
      OPC_OP       = 5'b01100,
      OPC_LUI      = 5'b01101,
      OPC_OP32     = 5'b01110,
      OPC_BRANCH   = 5'b11000,
      OPC_JALR     = 5'b11001,
      OPC_JAL      = 5'b11011,
      OPC_SYSTEM   = 5'b11100
   } opcode_e;

   typedef enum logic [1:0] {
      ISSUE_EMPTY = 2'd0,
      ISSUE_FULL  = 2'd1,
      ISSUE_TRAP  = 2'd2
   } issue_state_e;

   localparam int NUM_REGS = 32;

   function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [4:0] r);
      return NUM_REGS'(1) << r;
   endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Fetch, execute, writeback, flush and trap signals of the issue stage, plus debug taps.
interface issue_ctrl_if #(parameter int XLEN = 64);
   import ch0re_types::*;

   // valid/ready: a transfer fires on any rising edge where valid & ready are both 1;
   // once the sender raises valid, it holds valid and payload stable until fire or flush.
   logic             i_fetch_valid;
   logic             o_fetch_ready;
   logic [31:0]      i_fetch_instr;
   logic [XLEN-1:0]  i_fetch_pc;
   logic             o_ex_valid;
   logic             i_ex_ready;
   logic [31:0]      o_ex_instr;
   logic [XLEN-1:0]  o_ex_pc;
   logic             o_ex_is_load;
   logic             i_wb_valid;
   logic [4:0]       i_wb_rd;
   logic             i_flush;
   logic             o_trap;
   logic [XLEN-1:0]  o_trap_pc;
   logic [31:0]      o_trap_instr;
   logic             o_stall;
   issue_state_e     dbg_state;
   logic [31:0]      dbg_pending;

   // master: the issue controller; slave: the surrounding pipeline
   modport master (
      input  i_fetch_valid, i_fetch_instr, i_fetch_pc, i_ex_ready, i_wb_valid, i_wb_rd, i_flush,
      output o_fetch_ready, o_ex_valid, o_ex_instr, o_ex_pc, o_ex_is_load,
             o_trap, o_trap_pc, o_trap_instr, o_stall, dbg_state, dbg_pending
   );
   modport slave (
      output i_fetch_valid, i_fetch_instr, i_fetch_pc, i_ex_ready, i_wb_valid, i_wb_rd, i_flush,
      input  o_fetch_ready, o_ex_valid, o_ex_instr, o_ex_pc, o_ex_is_load,
             o_trap, o_trap_pc, o_trap_instr, o_stall, dbg_state, dbg_pending
   );
endinterface

// File: rtl/idecoder.sv
// RV64I field extractor and legality checker for one 32-bit instruction word.
module idecoder
   import ch0re_types::*;
(
   input  logic [31:0] i_instr,
   output opcode_e     o_opcode,
   output logic [4:0]  o_rd,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic        o_illegal_instr
);
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       legal;

   assign funct3   = i_instr[14:12];
   assign funct7   = i_instr[31:25];
   assign o_opcode = opcode_e'(i_instr[6:2]);
   assign o_rd     = i_instr[11:7];
   assign o_rs1    = i_instr[19:15];
   assign o_rs2    = i_instr[24:20];

   always_comb begin
      legal = 1'b0;
      if (i_instr[1:0] == 2'b11) begin
         case (o_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
            OPC_JALR:     legal = (funct3 == 3'b000);
            OPC_BRANCH:   legal = (funct3[2:1] != 2'b01);
            OPC_LOAD:     legal = (funct3 != 3'b111);
            OPC_STORE:    legal = !funct3[2];
            OPC_MISC_MEM: legal = (funct3 == 3'b000);
            // 64-bit shifts carry shamt[5] in bit 25, so only funct7[6:1] is checked
            OPC_OP_IMM: begin
               case (funct3)
                  3'b001:  legal = (funct7[6:1] == 6'b000000);
                  3'b101:  legal = (funct7[6:1] == 6'b000000) || (funct7[6:1] == 6'b010000);
                  default: legal = 1'b1;
               endcase
            end
            OPC_OP_IMM32: begin
               case (funct3)
                  3'b000:  legal = 1'b1;
                  3'b001:  legal = (funct7 == 7'b0000000);
                  3'b101:  legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                  default: legal = 1'b0;
               endcase
            end
            OPC_OP: legal = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            OPC_OP32: begin
               case (funct3)
                  3'b000, 3'b101: legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                  3'b001:         legal = (funct7 == 7'b0000000);
                  default:        legal = 1'b0;
               endcase
            end
            OPC_SYSTEM: legal = (i_instr[31:21] == 11'd0) && (i_instr[19:7] == 13'd0);
            default:    legal = 1'b0;
         endcase
      end
   end

   assign o_illegal_instr = !legal;

endmodule

// File: rtl/issue_ctrl.sv
// Decode/issue controller: one-entry decode register, load scoreboard, hazard stall and trap capture.
module issue_ctrl
   import ch0re_types::*;
#(
   parameter int XLEN = 64
) (
   input logic          i_clk,
   input logic          i_rst_n,
   issue_ctrl_if.master bus
);
   issue_state_e    state_q;
   logic [31:0]     instr_q, trap_instr_q;
   logic [XLEN-1:0] pc_q, trap_pc_q;
   logic [31:0]     pending_q, pending_d;

   opcode_e    opcode;
   logic [4:0] rd, rs1, rs2;
   logic       illegal;
   logic       uses_rs1, uses_rs2, writes_rd;
   logic       full, is_load, hazard, ex_valid, issue_fire, fetch_ready, fetch_fire;
   logic [31:0] wb_vec, set_vec, eff_pending;

   idecoder u_idecoder (
      .i_instr         (instr_q),
      .o_opcode        (opcode),
      .o_rd            (rd),
      .o_rs1           (rs1),
      .o_rs2           (rs2),
      .o_illegal_instr (illegal)
   );

   always_comb begin
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      case (opcode)
         OPC_OP, OPC_OP32:         begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
         OPC_OP_IMM, OPC_OP_IMM32: begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
         OPC_LOAD, OPC_JALR:       begin uses_rs1 = 1'b1; writes_rd = 1'b1; end
         OPC_STORE, OPC_BRANCH:    begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
         OPC_JAL, OPC_LUI, OPC_AUIPC: writes_rd = 1'b1;
         default: ;
      endcase
   end

   // A same-cycle writeback already releases the register it targets.
   assign wb_vec      = bus.i_wb_valid ? reg_onehot(bus.i_wb_rd) : 32'd0;
   assign eff_pending = pending_q & ~wb_vec;
   assign hazard      = (uses_rs1  && (rs1 != 5'd0) && eff_pending[rs1]) ||
                        (uses_rs2  && (rs2 != 5'd0) && eff_pending[rs2]) ||
                        (writes_rd && (rd  != 5'd0) && eff_pending[rd]);

   assign full        = (state_q == ISSUE_FULL);
   assign is_load     = full && (opcode == OPC_LOAD);
   assign ex_valid    = full && !illegal && !hazard;
   assign issue_fire  = ex_valid && bus.i_ex_ready;
   assign fetch_ready = i_rst_n && !bus.i_flush && ((state_q == ISSUE_EMPTY) || (full && issue_fire));
   assign fetch_fire  = bus.i_fetch_valid && fetch_ready;

   // Set beats a same-cycle clear so a reissued load keeps its register reserved.
   assign set_vec   = (issue_fire && is_load && (rd != 5'd0)) ? reg_onehot(rd) : 32'd0;
   assign pending_d = ((pending_q & ~wb_vec) | set_vec) & ~32'd1;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ISSUE_EMPTY;
         instr_q      <= '0;
         pc_q         <= '0;
         trap_instr_q <= '0;
         trap_pc_q    <= '0;
      end else if (bus.i_flush) begin
         state_q <= ISSUE_EMPTY;
      end else begin
         case (state_q)
            ISSUE_EMPTY: begin
               if (fetch_fire) begin
                  instr_q <= bus.i_fetch_instr;
                  pc_q    <= bus.i_fetch_pc;
                  state_q <= ISSUE_FULL;
               end
            end
            ISSUE_FULL: begin
               if (illegal) begin
                  trap_instr_q <= instr_q;
                  trap_pc_q    <= pc_q;
                  state_q      <= ISSUE_TRAP;
               end else if (issue_fire) begin
                  if (fetch_fire) begin
                     instr_q <= bus.i_fetch_instr;
                     pc_q    <= bus.i_fetch_pc;
                  end else begin
                     state_q <= ISSUE_EMPTY;
                  end
               end
            end
            default: state_q <= ISSUE_TRAP;
         endcase
      end
   end

   assign bus.o_fetch_ready = fetch_ready;
   assign bus.o_ex_valid    = ex_valid;
   assign bus.o_ex_instr    = instr_q;
   assign bus.o_ex_pc       = pc_q;
   assign bus.o_ex_is_load  = is_load;
   assign bus.o_trap        = (state_q == ISSUE_TRAP);
   assign bus.o_trap_pc     = trap_pc_q;
   assign bus.o_trap_instr  = trap_instr_q;
   assign bus.o_stall       = full && !illegal && hazard;
   assign bus.dbg_state     = state_q;
   assign bus.dbg_pending   = pending_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: issue, streaming, load hazards, x0, trap/flush, backpressure, reset.
module tb_issue_ctrl;
  import ch0re_types::*;

  logic clk;
  logic rst_n;
  int checks;
  int failures;

  issue_ctrl_if #(.XLEN(64)) bus ();

  issue_ctrl #(.XLEN(64)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.i_fetch_valid = 1'b0;
    bus.i_fetch_instr = 32'd0;
    bus.i_fetch_pc    = 64'd0;
    bus.i_ex_ready    = 1'b0;
    bus.i_wb_valid    = 1'b0;
    bus.i_wb_rd       = 5'd0;
    bus.i_flush       = 1'b0;
  endtask

  task automatic drive_fetch(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    bus.i_fetch_valid = v;
    bus.i_fetch_instr = ins;
    bus.i_fetch_pc    = pc;
  endtask

  // Inputs change just after a falling edge; outputs are checked 1 ns later.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    @(negedge clk);
    #1;
    checks++; if (bus.o_ex_valid !== 1'b0) begin failures++; $display("FAIL rst_ex_valid got=%h exp=%h", bus.o_ex_valid, 1'b0); end
    checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL rst_fetch_ready got=%h exp=%h", bus.o_fetch_ready, 1'b0); end
    checks++; if (bus.o_trap !== 1'b0) begin failures++; $display("FAIL rst_trap got=%h exp=%h", bus.o_trap, 1'b0); end
    checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%h exp=%h", bus.o_stall, 1'b0); end
    checks++; if (bus.o_ex_is_load !== 1'b0) begin failures++; $display("FAIL rst_is_load got=%h exp=%h", bus.o_ex_is_load, 1'b0); end
    checks++; if (bus.o_ex_pc !== 64'd0) begin failures++; $display("FAIL rst_ex_pc got=%h exp=%h", bus.o_ex_pc, 64'd0); end
    checks++; if (bus.o_trap_pc !== 64'd0) begin failures++; $display("FAIL rst_trap_pc got=%h exp=%h", bus.o_trap_pc, 64'd0); end
    checks++; if (bus.dbg_pending !== 32'd0) begin failures++; $display("FAIL rst_pending got=%h exp=%h", bus.dbg_pending, 32'd0); end
    checks++; if (bus.dbg_state !== ISSUE_EMPTY) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", bus.dbg_state, ISSUE_EMPTY); end
    rst_n = 1'b1;
    #1;
    checks++; if (bus.o_fetch_ready !== 1'b1) begin failures++; $display("FAIL rst_release_fetch_ready got=%h exp=%h", bus.o_fetch_ready, 1'b1); end
    next_cycle();
  endtask

  task automatic test_issue();
    bus.i_ex_ready = 1'b1;
    drive_fetch(1'b1, 32'h00500093, 64'h1000);
    #1;
    checks++; if (bus.o_ex_valid !== 1'b0) begin failures++; $display("FAIL issue_c0_ex_valid got=%h exp=%h", bus.o_ex_valid, 1'b0); end
    next_cycle();
    drive_fetch(1'b0, 32'd0, 64'd0);
    #1;
    checks++; if (bus.o_ex_valid !== 1'b1) begin failures++; $display("FAIL issue_ex_valid got=%h exp=%h", bus.o_ex_valid, 1'b1); end
    checks++; if (bus.o_ex_pc !== 64'h1000) begin failures++; $display("FAIL issue_ex_pc got=%h exp=%h", bus.o_ex_pc, 64'h1000); end
    checks++; if (bus.o_ex_instr !== 32'h00500093) begin failures++; $display("FAIL issue_ex_instr got=%h exp=%h", bus.o_ex_instr, 32'h00500093); end
    checks++; if (bus.o_ex_is_load !== 1'b0) begin failures++; $display("FAIL issue_is_load got=%h exp=%h", bus.o_ex_is_load, 1'b0); end
    next_cycle();
    #1;
    checks++; if (bus.dbg_state !== ISSUE_EMPTY) begin failures++; $display("FAIL issue_after_state got=%0d exp=%0d", bus.dbg_state, ISSUE_EMPTY); end
    checks++; if (bus.o_ex_valid !== 1'b0) begin failures++; $display("FAIL issue_after_ex_valid got=%h exp=%h", bus.o_ex_valid, 1'b0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    logic [31:0] prev_ins;
    bus.i_ex_ready = 1'b1;
    prev_ins = 32'd0;
    for (int i = 0; i < 5; i++) begin
      ins = {12'd5, 5'd0, 3'b000, 5'(i + 1), 7'b0010011};
      if (i < 4) drive_fetch(1'b1, ins, 64'h1100 + 64'(4 * i));
      else drive_fetch(1'b0, 32'd0, 64'd0);
      #1;
      if (i > 0) begin
        checks++; if (bus.o_ex_valid !== 1'b1) begin failures++; $display("FAIL b2b_ex_valid_%0d got=%h exp=%h", i, bus.o_ex_valid, 1'b1); end
        checks++; if (bus.o_ex_pc !== 64'h1100 + 64'(4 * (i - 1))) begin failures++; $display("FAIL b2b_ex_pc_%0d got=%h exp=%h", i, bus.o_ex_pc, 64'h1100 + 64'(4 * (i - 1))); end
        checks++; if (bus.o_ex_instr !== prev_ins) begin failures++; $display("FAIL b2b_ex_instr_%0d got=%h exp=%h", i, bus.o_ex_instr, prev_ins); end
      end
      if (i < 4) begin
        checks++; if (bus.o_fetch_ready !== 1'b1) begin failures++; $display("FAIL b2b_fetch_ready_%0d got=%h exp=%h", i, bus.o_fetch_ready, 1'b1); end
      end
      prev_ins = ins;
      next_cycle();
    end
    #1;
    checks++; if (bus.dbg_state !== ISSUE_EMPTY) begin failures++; $display("FAIL b2b_end_state got=%0d exp=%0d", bus.dbg_state, ISSUE_EMPTY); end
  endtask

  task automatic test_load_hazard();
    bus.i_ex_ready = 1'b1;
    drive_fetch(1'b1, 32'h0000a103, 64'h3000);
    next_cycle();
    drive_fetch(1'b1, 32'h001101b3, 64'h3004);
    #1;
    checks++; if (bus.o_ex_valid !== 1'b1) begin failures++; $display("FAIL lw_ex_valid got=%h exp=%h", bus.o_ex_valid, 1'b1); end
    checks++; if (bus.o_ex_is_load !== 1'b1) begin failures++; $display("FAIL lw_is_load got=%h exp=%h", bus.o_ex_is_load, 1'b1); end
    checks++; if (bus.o_fetch_ready !== 1'b1) begin failures++; $display("FAIL lw_fetch_ready got=%h exp=%h", bus.o_fetch_ready, 1'b1); end
    next_cycle();
    drive_fetch(1'b0, 32'd0, 64'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL add_stall_%0d got=%h exp=%h", i, bus.o_stall, 1'b1); end
      checks++; if (bus.o_ex_valid !== 1'b0) begin failures++; $display("FAIL add_stalled_ex_valid_%0d got=%h exp=%h", i, bus.o_ex_valid, 1'b0); end
      checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL add_stalled_fetch_ready_%0d got=%h exp=%h", i, bus.o_fetch_ready, 1'b0); end
      checks++; if (bus.dbg_pending !== 32'h4) begin failures++; $display("FAIL lw_pending_%0d got=%h exp=%h", i, bus.dbg_pending, 32'h4); end
      next_cycle();
    end
    bus.i_wb_valid = 1'b1;
    bus.i_wb_rd    = 5'd2;
    #1;
    checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL wb_release_stall got=%h exp=%h", bus.o_stall, 1'b0); end
    checks++; if (bus.o_ex_valid !== 1'b1) begin failures++; $display("FAIL wb_release_ex_valid got=%h exp=%h", bus.o_ex_valid, 1'b1); end
    checks++; if (bus.o_ex_pc !== 64'h3004) begin failures++; $display("FAIL wb_release_ex_pc got=%h exp=%h", bus.o_ex_pc, 64'h3004); end
    next_cycle();
    bus.i_wb_valid = 1'b0;
    bus.i_wb_rd    = 5'd0;
    #1;
    checks++; if (bus.dbg_pending !== 32'd0) begin failures++; $display("FAIL wb_cleared_pending got=%h exp=%h", bus.dbg_pending, 32'd0); end
    checks++; if (bus.dbg_state !== ISSUE_EMPTY) begin failures++; $display("FAIL wb_end_state got=%0d exp=%0d", bus.dbg_state, ISSUE_EMPTY); end
  endtask

  task automatic test_x0();
    bus.i_ex_ready = 1'b1;
    drive_fetch(1'b1, 32'h0000a003, 64'h4000);
    next_cycle();
    drive_fetch(1'b1, 32'h00000013, 64'h4004);
    #1;
    checks++; if (bus.o_ex_valid !== 1'b1) begin failures++; $display("FAIL x0_lw_ex_valid got=%h exp=%h", bus.o_ex_valid, 1'b1); end
    next_cycle();
    drive_fetch(1'b0, 32'd0, 64'd0);
    #1;
    checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%h exp=%h", bus.o_stall, 1'b0); end
    checks++; if (bus.o_ex_valid !== 1'b1) begin failures++; $display("FAIL x0_addi_ex_valid got=%h exp=%h", bus.o_ex_valid, 1'b1); end
    checks++; if (bus.dbg_pending !== 32'd0) begin failures++; $display("FAIL x0_pending got=%h exp=%h", bus.dbg_pending, 32'd0); end
    next_cycle();
    #1;
    checks++; if (bus.dbg_pending !== 32'd0) begin failures++; $display("FAIL x0_pending_end got=%h exp=%h", bus.dbg_pending, 32'd0); end
  endtask

  task automatic test_trap();
    bus.i_ex_ready = 1'b1;
    drive_fetch(1'b1, 32'h00000000, 64'h2000);
    #1;
    checks++; if (bus.o_fetch_ready !== 1'b1) begin failures++; $display("FAIL trap_capture_ready got=%h exp=%h", bus.o_fetch_ready, 1'b1); end
    next_cycle();
    drive_fetch(1'b1, 32'h00500093, 64'h2004);
    #1;
    checks++; if (bus.dbg_state !== ISSUE_FULL) begin failures++; $display("FAIL trap_n1_state got=%0d exp=%0d", bus.dbg_state, ISSUE_FULL); end
    checks++; if (bus.o_ex_valid !== 1'b0) begin failures++; $display("FAIL trap_n1_ex_valid got=%h exp=%h", bus.o_ex_valid, 1'b0); end
    checks++; if (bus.o_trap !== 1'b0) begin failures++; $display("FAIL trap_n1_trap got=%h exp=%h", bus.o_trap, 1'b0); end
    checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL trap_n1_fetch_ready got=%h exp=%h", bus.o_fetch_ready, 1'b0); end
    checks++; if (bus.o_stall !== 1'b0) begin failures++; $display("FAIL trap_n1_stall got=%h exp=%h", bus.o_stall, 1'b0); end
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (bus.o_trap !== 1'b1) begin failures++; $display("FAIL trap_held_%0d got=%h exp=%h", i, bus.o_trap, 1'b1); end
      checks++; if (bus.o_trap_pc !== 64'h2000) begin failures++; $display("FAIL trap_pc_%0d got=%h exp=%h", i, bus.o_trap_pc, 64'h2000); end
      checks++; if (bus.o_trap_instr !== 32'h00000000) begin failures++; $display("FAIL trap_instr_%0d got=%h exp=%h", i, bus.o_trap_instr, 32'h00000000); end
      checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL trap_fetch_blocked_%0d got=%h exp=%h", i, bus.o_fetch_ready, 1'b0); end
      checks++; if (bus.o_ex_valid !== 1'b0) begin failures++; $display("FAIL trap_ex_valid_%0d got=%h exp=%h", i, bus.o_ex_valid, 1'b0); end
      next_cycle();
    end
    bus.i_flush = 1'b1;
    #1;
    checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL flush_fetch_ready got=%h exp=%h", bus.o_fetch_ready, 1'b0); end
    next_cycle();
    bus.i_flush = 1'b0;
    drive_fetch(1'b0, 32'd0, 64'd0);
    #1;
    checks++; if (bus.o_trap !== 1'b0) begin failures++; $display("FAIL flush_trap got=%h exp=%h", bus.o_trap, 1'b0); end
    checks++; if (bus.dbg_state !== ISSUE_EMPTY) begin failures++; $display("FAIL flush_state got=%0d exp=%0d", bus.dbg_state, ISSUE_EMPTY); end
    checks++; if (bus.o_fetch_ready !== 1'b1) begin failures++; $display("FAIL flush_after_ready got=%h exp=%h", bus.o_fetch_ready, 1'b1); end
  endtask

  task automatic test_backpressure();
    bus.i_ex_ready = 1'b0;
    drive_fetch(1'b1, 32'h00500093, 64'h5000);
    next_cycle();
    drive_fetch(1'b1, 32'h00700113, 64'h5004);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.o_ex_valid !== 1'b1) begin failures++; $display("FAIL bp_ex_valid_%0d got=%h exp=%h", i, bus.o_ex_valid, 1'b1); end
      checks++; if (bus.o_ex_pc !== 64'h5000) begin failures++; $display("FAIL bp_ex_pc_%0d got=%h exp=%h", i, bus.o_ex_pc, 64'h5000); end
      checks++; if (bus.o_ex_instr !== 32'h00500093) begin failures++; $display("FAIL bp_ex_instr_%0d got=%h exp=%h", i, bus.o_ex_instr, 32'h00500093); end
      checks++; if (bus.o_fetch_ready !== 1'b0) begin failures++; $display("FAIL bp_fetch_ready_%0d got=%h exp=%h", i, bus.o_fetch_ready, 1'b0); end
      next_cycle();
    end
    bus.i_ex_ready = 1'b1;
    #1;
    checks++; if (bus.o_fetch_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%h exp=%h", bus.o_fetch_ready, 1'b1); end
    next_cycle();
    drive_fetch(1'b0, 32'd0, 64'd0);
    #1;
    checks++; if (bus.o_ex_pc !== 64'h5004) begin failures++; $display("FAIL bp_second_pc got=%h exp=%h", bus.o_ex_pc, 64'h5004); end
    checks++; if (bus.o_ex_valid !== 1'b1) begin failures++; $display("FAIL bp_second_valid got=%h exp=%h", bus.o_ex_valid, 1'b1); end
    next_cycle();
  endtask

  task automatic test_set_wins();
    bus.i_ex_ready = 1'b1;
    drive_fetch(1'b1, 32'h0000a283, 64'h6000);
    next_cycle();
    drive_fetch(1'b0, 32'd0, 64'd0);
    next_cycle();
    drive_fetch(1'b1, 32'h0000a283, 64'h6004);
    next_cycle();
    drive_fetch(1'b0, 32'd0, 64'd0);
    #1;
    checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL sw_waw_stall got=%h exp=%h", bus.o_stall, 1'b1); end
    bus.i_flush = 1'b1;
    next_cycle();
    bus.i_flush = 1'b0;
    #1;
    checks++; if (bus.dbg_state !== ISSUE_EMPTY) begin failures++; $display("FAIL sw_flush_state got=%0d exp=%0d", bus.dbg_state, ISSUE_EMPTY); end
    checks++; if (bus.dbg_pending !== 32'h20) begin failures++; $display("FAIL sw_flush_keeps_pending got=%h exp=%h", bus.dbg_pending, 32'h20); end
    drive_fetch(1'b1, 32'h0000a283, 64'h6008);
    next_cycle();
    drive_fetch(1'b0, 32'd0, 64'd0);
    #1;
    checks++; if (bus.o_stall !== 1'b1) begin failures++; $display("FAIL sw_second_stall got=%h exp=%h", bus.o_stall, 1'b1); end
    next_cycle();
    bus.i_wb_valid = 1'b1;
    bus.i_wb_rd    = 5'd5;
    #1;
    checks++; if (bus.o_ex_valid !== 1'b1) begin failures++; $display("FAIL sw_issue_with_wb got=%h exp=%h", bus.o_ex_valid, 1'b1); end
    next_cycle();
    bus.i_wb_valid = 1'b0;
    bus.i_wb_rd    = 5'd0;
    #1;
    checks++; if (bus.dbg_pending !== 32'h20) begin failures++; $display("FAIL sw_set_wins got=%h exp=%h", bus.dbg_pending, 32'h20); end
    checks++; if (bus.dbg_state !== ISSUE_EMPTY) begin failures++; $display("FAIL sw_end_state got=%0d exp=%0d", bus.dbg_state, ISSUE_EMPTY); end
  endtask

  task automatic test_reset_mid();
    bus.i_ex_ready = 1'b0;
    drive_fetch(1'b1, 32'h00500093, 64'h7000);
    next_cycle();
    drive_fetch(1'b0, 32'd0, 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.dbg_pending !== 32'd0) begin failures++; $display("FAIL mid_rst_pending got=%h exp=%h", bus.dbg_pending, 32'd0); end
    checks++; if (bus.dbg_state !== ISSUE_EMPTY) begin failures++; $display("FAIL mid_rst_state got=%0d exp=%0d", bus.dbg_state, ISSUE_EMPTY); end
    checks++; if (bus.o_ex_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_ex_valid got=%h exp=%h", bus.o_ex_valid, 1'b0); end
    checks++; if (bus.o_ex_pc !== 64'd0) begin failures++; $display("FAIL mid_rst_ex_pc got=%h exp=%h", bus.o_ex_pc, 64'd0); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    set_idle();
    test_reset();
    test_issue();
    test_back_to_back();
    test_load_hazard();
    test_x0();
    test_trap();
    test_backpressure();
    test_set_wins();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
